keypad_fifo_b3: RTL and testbench
=================================

KEYPAD_FIFO_B3 -- requirements
Module: keypad_fifo_b3

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles each column is driven before rows are sampled.
REQ-002 SHALL have parameter DEB_SCANS, default 4, meaning consecutive full scans needed to accept a press or a release.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning keycode FIFO entries (power of 2, 2..16).
REQ-004 SHALL have ports:
- clk  in  1  system clock (one clock domain).
- reset  in  1  synchronous, active-high reset.
- addr  in  1  register select: 0 = data, 1 = status.
- re  in  1  read enable.
- we  in  1  write enable.
- data_in  in  8  write data.
- data_out  out  8  read data; 0 when re = 0.
- row  in  4  keypad rows, active-low.
- col  out  4  keypad columns, one-hot-low drive.
- irq  out  1  high while the FIFO is not empty.

Function
REQ-005 SHALL drive col through 1110, 1101, 1011, 0111 and wrap, advancing every SCAN_DIV cycles.
REQ-006 SHALL sample row on the last cycle of each column dwell.
REQ-007 SHALL form a scan result from the 4 column samples: exactly one low row bit across the whole scan gives keycode = row_idx*4 + col_idx (0..15); zero or more than one low bit gives NONE.
REQ-008 SHALL implement an FSM with states IDLE, DEBOUNCE, HELD and RELEASE, evaluated once per completed scan.
REQ-009 IDLE SHALL go to DEBOUNCE on a scan result other than NONE, latching it as the candidate.
REQ-010 DEBOUNCE SHALL go to HELD after DEB_SCANS consecutive scans equal to the candidate, pushing the candidate once; any other result SHALL return it to IDLE.
REQ-011 HELD SHALL go to RELEASE on NONE or on a different keycode.
REQ-012 RELEASE SHALL go to IDLE after DEB_SCANS consecutive NONE scans; a non-NONE scan SHALL return it to HELD with no push.
REQ-013 SHALL store each pushed byte as {4'b0000, keycode}.
REQ-014 A read with addr = 0 SHALL present the FIFO head combinationally and pop it at the clock edge; reading an empty FIFO SHALL return 0x00 with no pop.
REQ-015 A read with addr = 1 SHALL return status: bit0 not_empty, bit1 full, bit2 overflow (sticky), bit3 0, bits7:4 count saturated at 15.
REQ-016 A push while full and not simultaneously popped SHALL be dropped and SHALL set overflow.
REQ-017 A simultaneous push and pop SHALL both take effect with no overflow, including when the FIFO is full.
REQ-018 A write with addr = 1 and data_in bit2 = 1 SHALL clear overflow; overflow being set in the same cycle SHALL win.
REQ-019 Writes with addr = 0 SHALL be ignored.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 On reset = 1 at a clk edge, SHALL apply: FIFO emptied, overflow = 0, FSM = IDLE, scan counters = 0, col = 1110, irq = 0.
REQ-022 Reset asserted mid-scan or mid-debounce SHALL discard the partial scan; scanning restarts at column 0.

Configuration
REQ-023 With macro KEYPAD_AUTOREPEAT_EN defined, HELD SHALL push the held keycode again after 32 scans, then every 8 scans, while the same keycode persists; the repeat counter restarts on entry to HELD.
REQ-024 Without KEYPAD_AUTOREPEAT_EN, SHALL push exactly one entry per accepted press, and the repeat logic SHALL not be synthesised.

Verification
REQ-025 SHALL use SCAN_DIV = 4 and DEB_SCANS = 2 for all benches.
REQ-026 Single press: hold row1 low in col2 for 5 scans, then release -> exactly one entry 0x06, irq = 1, status 0x11.
REQ-027 Bounce: alternate key 0x06 and NONE on successive scans for 6 scans -> FIFO stays empty.
REQ-028 Overflow: 9 distinct press/release cycles with FIFO_DEPTH = 8 and no reads -> status 0x87; a write of 0x04 to addr 1 -> status 0x83.
REQ-029 Full with simultaneous pop: FIFO full, read addr 0 in the same cycle a push occurs -> count stays 8, overflow = 0, head advances.
REQ-030 Two keys: rows 0 and 1 low together -> NONE, no push; empty FIFO read of addr 0 -> 0x00.
REQ-031 Autorepeat (macro defined): hold key 0x0F for 50 scans -> 1 + 1 + 2 = 4 entries of 0x0F; macro undefined -> 1 entry.

Source files
------------

// File: rtl/keypad_fifo_b3.sv
// rtl/keypad_fifo_b3.sv - 4x4 keypad scanner, debounce FSM and keycode FIFO with register port
// Define KEYPAD_AUTOREPEAT_EN to add held-key autorepeat (32 scans, then every 8 scans).
module keypad_fifo_b3 #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_SCANS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       addr,
    input  logic       re,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       irq
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int DEB_W = $clog2(DEB_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_SCANS);
    localparam bit DEB_ONE = (DEB_SCANS <= 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       low_cnt_q, low_cnt_d;
    logic [3:0]       key_acc_q, key_acc_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [5:0]       rep_q, rep_d;
`endif

    logic       scan_done, scan_hit, sample;
    logic [3:0] scan_key, key_new, row_low, push_key;
    logic [2:0] n_low, sum;
    logic [1:0] row_idx;
    logic       push, pop, full, push_ok, ovf_set, ovf_clr;
    logic [4:0] cnt5;
    logic [3:0] cnt_sat;
    logic [7:0] status;
    logic       unused_ok;

    assign unused_ok = ^{data_in[7:3], data_in[1:0]};
    assign col       = ~(4'b0001 << col_idx_q);
    assign irq       = (count_q != '0);

    // Low bits are accumulated across the four columns; the count saturates at 2 (meaning "many").
    always_comb begin
        div_d     = div_q + 1'b1;
        col_idx_d = col_idx_q;
        low_cnt_d = low_cnt_q;
        key_acc_d = key_acc_q;
        row_low   = ~row;
        n_low     = {2'b00, row_low[0]} + {2'b00, row_low[1]} + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        row_idx   = row_low[0] ? 2'd0 : row_low[1] ? 2'd1 : row_low[2] ? 2'd2 : 2'd3;
        sum       = {1'b0, low_cnt_q} + n_low;
        key_new   = (n_low == 3'd1) ? {row_idx, col_idx_q} : key_acc_q;
        sample    = (div_q == DIV_LAST);
        scan_done = 1'b0;
        scan_hit  = 1'b0;
        scan_key  = key_new;
        if (sample) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            if (col_idx_q == 2'd3) begin
                scan_done = 1'b1;
                scan_hit  = (sum == 3'd1);
                low_cnt_d = '0;
                key_acc_d = '0;
            end else begin
                low_cnt_d = (sum > 3'd2) ? 2'd2 : sum[1:0];
                key_acc_d = key_new;
            end
        end
    end

    assign deb_inc = deb_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        deb_d    = deb_q;
        push     = 1'b0;
        push_key = cand_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d    = rep_q;
`endif
        if (scan_done) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_hit) begin
                        cand_d   = scan_key;
                        push_key = scan_key;
                        deb_d    = DEB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d    = '0;
`endif
                        if (DEB_ONE) begin
                            state_d = S_HELD;
                            push    = 1'b1;
                        end else begin
                            state_d = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (scan_hit && scan_key == cand_q) begin
                        deb_d = deb_inc;
                        if (deb_inc >= DEB_MAX) begin
                            state_d = S_HELD;
                            push    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (scan_hit && scan_key == cand_q) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        // Reloading 24 after the first repeat gives the 8-scan cadence.
                        rep_d = rep_q + 6'd1;
                        if (rep_d == 6'd32) begin
                            push  = 1'b1;
                            rep_d = 6'd24;
                        end
`endif
                    end else begin
                        deb_d   = scan_hit ? '0 : DEB_W'(1);
                        state_d = (!scan_hit && DEB_ONE) ? S_IDLE : S_REL;
                    end
                end
                default: begin
                    if (scan_hit) begin
                        state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        deb_d = deb_inc;
                        if (deb_inc >= DEB_MAX) state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pop      = re && !addr && (count_q != '0);
        full     = (count_q == FULL_CNT);
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;
        ovf_clr  = we && addr && data_in[2];
        ovf_d    = (ovf_q && !ovf_clr) || ovf_set;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        cnt5     = 5'(count_q);
        cnt_sat  = (cnt5 > 5'd15) ? 4'hF : cnt5[3:0];
        status   = {cnt_sat, 1'b0, ovf_q, full, count_q != '0};
        data_out = 8'h00;
        if (re) data_out = addr ? status : ((count_q != '0) ? mem_q[rd_ptr_q] : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            col_idx_q <= '0;
            low_cnt_q <= '0;
            key_acc_q <= '0;
            state_q   <= S_IDLE;
            cand_q    <= '0;
            deb_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            low_cnt_q <= low_cnt_d;
            key_acc_q <= key_acc_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            deb_q     <= deb_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem_q[wr_ptr_q] <= {4'b0000, push_key};
    end

endmodule

// File: tb/tb_keypad_fifo_b3.sv
// tb/tb_keypad_fifo_b3.sv - scan-level reference model with per-cycle compare and directed keypad scenarios
module tb_keypad_fifo_b3;
    localparam int SD   = 4;
    localparam int DS   = 2;
    localparam int FD   = 8;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       addr = 1'b0, re = 1'b0, we = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [3:0] row_drv, col;
    logic       irq;
    logic [15:0] key_mask = 16'h0000;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_fifo_b3 #(.SCAN_DIV(SD), .DEB_SCANS(DS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .addr(addr), .re(re), .we(we),
        .data_in(data_in), .data_out(data_out), .row(row_drv), .col(col), .irq(irq)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && key_mask[r*4+c]) row_drv[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan boundaries by cycle arithmetic, FIFO as a queue.
    localparam int M_IDLE = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;
    int         cyc = 0;
    logic [7:0] mq[$];
    bit         m_ovf = 0, started = 0;
    int         m_state = M_IDLE, m_cand = 0, m_cnt = 0, m_rep = 0, res;
    bit         m_push, m_pop, m_drop, m_clr;

    function automatic int scan_res(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int k = 0; k < 16; k++) if (m[k]) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cyc = 0; mq.delete(); m_ovf = 0; m_state = M_IDLE; m_cnt = 0; m_rep = 0; started = 1;
        end else begin
            m_push = 0;
            if (cyc % SCAN == SCAN - 1) begin
                res = scan_res(key_mask);
                case (m_state)
                    M_IDLE: if (res >= 0) begin
                        m_cand = res; m_cnt = 1; m_rep = 0; m_state = M_DEB;
                        if (m_cnt >= DS) begin m_state = M_HELD; m_push = 1; end
                    end
                    M_DEB: if (res == m_cand) begin
                        m_cnt++;
                        if (m_cnt >= DS) begin m_state = M_HELD; m_push = 1; m_rep = 0; end
                    end else m_state = M_IDLE;
                    M_HELD: if (res == m_cand) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        m_rep++;
                        if (m_rep >= 32 && (m_rep - 32) % 8 == 0) m_push = 1;
`endif
                    end else begin
                        m_cnt = (res < 0) ? 1 : 0;
                        m_state = (m_cnt >= DS) ? M_IDLE : M_REL;
                    end
                    default: if (res >= 0) begin m_state = M_HELD; m_rep = 0; end
                    else begin m_cnt++; if (m_cnt >= DS) m_state = M_IDLE; end
                endcase
            end
            m_pop  = re && !addr && mq.size() > 0;
            m_clr  = we && addr && data_in[2];
            m_drop = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < FD) mq.push_back(8'(m_cand));
                else m_drop = 1;
            end
            m_ovf = (m_ovf && !m_clr) || m_drop;
            cyc++;
        end
    end

    function automatic logic [7:0] exp_status();
        int n = mq.size();
        return {4'((n > 15) ? 15 : n), 1'b0, m_ovf, n == FD, n > 0};
    endfunction

    always @(negedge clk) begin
        logic [3:0] ecol;
        logic [7:0] edo;
        if (started) begin
            ecol = ~(4'b0001 << ((cyc / SD) % 4));
            edo  = 8'h00;
            if (re) edo = addr ? exp_status() : ((mq.size() > 0) ? mq[0] : 8'h00);
            chk("col", {4'h0, col}, {4'h0, ecol});
            chk("irq", {7'h0, irq}, {7'h0, mq.size() > 0});
            chk("data_out", data_out, edo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        re = 0; we = 0; reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic scan(input logic [15:0] m, input bit rnd_bus, input bit rd_last);
        while (cyc % SCAN != 0) tick();
        key_mask = m;
        for (int i = 0; i < SCAN; i++) begin
            if (rnd_bus) begin
                re = ($urandom_range(3) == 0); addr = 1'($urandom_range(1));
                we = ($urandom_range(7) == 0); data_in = 8'($urandom);
            end
            if (rd_last && i == SCAN - 1) begin re = 1; addr = 0; end
            tick();
            re = 0; we = 0;
        end
    endtask

    task automatic bus_read(input logic a, input logic [7:0] exp, input string name);
        re = 1; addr = a;
        @(negedge clk);
        chk(name, data_out, exp);
        tick();
        re = 0;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        we = 1; addr = a; data_in = d;
        tick();
        we = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r, len;
        logic [15:0] m;
        do_reset();
        chk("reset_col", {4'h0, col}, 8'h0E);
        chk("reset_irq", {7'h0, irq}, 8'h00);
        bus_read(1, 8'h00, "reset_status");

        for (int i = 0; i < 5; i++) scan(16'h0040, 0, 0);
        for (int i = 0; i < 3; i++) scan(16'h0000, 0, 0);
        chk("single_irq", {7'h0, irq}, 8'h01);
        bus_read(1, 8'h11, "single_status");
        bus_read(0, 8'h06, "single_data");
        bus_read(1, 8'h00, "single_empty");

        do_reset();
        for (int i = 0; i < 6; i++) scan((i % 2 == 0) ? 16'h0040 : 16'h0000, 0, 0);
        scan(16'h0000, 0, 0);
        bus_read(1, 8'h00, "bounce_status");

        do_reset();
        for (int i = 0; i < 4; i++) scan(16'h0044, 0, 0);
        bus_read(1, 8'h00, "twokey_status");
        bus_read(0, 8'h00, "empty_read");

        do_reset();
        for (int k = 0; k < 9; k++) begin
            scan(16'(1 << k), 0, 0); scan(16'(1 << k), 0, 0);
            scan(16'h0000, 0, 0); scan(16'h0000, 0, 0);
        end
        bus_read(1, 8'h87, "ovf_status");
        bus_write(1, 8'h04);
        bus_read(1, 8'h83, "ovf_cleared");
        scan(16'h0200, 0, 0);
        scan(16'h0200, 0, 1);
        scan(16'h0000, 0, 0); scan(16'h0000, 0, 0);
        bus_read(1, 8'h83, "fullpop_status");
        bus_read(0, 8'h01, "fullpop_head");

        do_reset();
        scan(16'h0040, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        do_reset();
        chk("midreset_col", {4'h0, col}, 8'h0E);
        for (int i = 0; i < 3; i++) scan(16'h0020, 0, 0);
        for (int i = 0; i < 3; i++) scan(16'h0000, 0, 0);
        bus_read(1, 8'h11, "midreset_status");
        bus_read(0, 8'h05, "midreset_data");

        do_reset();
        for (int i = 0; i < 50; i++) scan(16'h8000, 0, 0);
        for (int i = 0; i < 3; i++) scan(16'h0000, 0, 0);
`ifdef KEYPAD_AUTOREPEAT_EN
        bus_read(1, 8'h41, "repeat_status");
        for (int i = 0; i < 4; i++) bus_read(0, 8'h0F, "repeat_data");
`else
        bus_read(1, 8'h11, "repeat_status");
        bus_read(0, 8'h0F, "repeat_data");
`endif

        do_reset();
        for (int s = 0; s < 200; s++) begin
            r = $urandom_range(99);
            if (r < 60) begin m = 16'(1 << $urandom_range(15)); len = $urandom_range(6, 1); end
            else if (r < 85) begin m = 16'h0000; len = $urandom_range(4, 1); end
            else begin
                m = 16'(1 << $urandom_range(15)) | 16'(1 << $urandom_range(15));
                len = $urandom_range(3, 1);
            end
            for (int i = 0; i < len; i++) scan(m, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
